gate_bist_ctrl: RTL and testbench

//  Built-in self-test sequencer for a 2-input combinational gate (and_gate by default).
//  On start it drives the four input vectors 00,01,10,11 onto the gate.

---
 rtl/gate_bist_ctrl.sv | 125 ++++++++++++
 tb/tb_gate_bist_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for a 2-input gate: applies vectors 00..11, samples after a settle time,
// and counts mismatches against TRUTH. Optional first-failure log via GATE_BIST_FAIL_LOG_EN.
module gate_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  TRUTH         = 4'b1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       gate_a_o,
  output logic       gate_b_o,
  input  logic       gate_out_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [2:0] err_count_o,
  output logic [1:0] vec_idx_o,
  output logic [2:0] first_fail_o
);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

  localparam logic [3:0] CntLast = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic [2:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       start_run;
  logic       mismatch;

  // start is only honoured when no run is in flight
  assign start_run = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign mismatch  = (state_q == StCheck) && (gate_out_i != TRUTH[vec_q]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_run) begin
          state_d = StDrive;
          cnt_d   = 4'd0;
          vec_d   = 2'd0;
          err_d   = 3'd0;
          pass_d  = 1'b0;
        end
      end
      StDrive: begin
        if (cnt_q == CntLast) begin
          state_d = StCheck;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StCheck: begin
        if (mismatch) err_d = err_q + 3'd1;
        if (vec_q == 2'd3) begin
          state_d = StDone;
          pass_d  = (err_d == 3'd0);
        end else begin
          vec_d   = vec_q + 2'd1;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      vec_q   <= 2'd0;
      err_q   <= 3'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign busy_o      = (state_q == StDrive) || (state_q == StCheck);
  assign done_o      = (state_q == StDone);
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign vec_idx_o   = vec_q;
  // Gate inputs park at 00 outside a run
  assign gate_a_o    = busy_o & vec_q[1];
  assign gate_b_o    = busy_o & vec_q[0];

`ifdef GATE_BIST_FAIL_LOG_EN
  logic [2:0] ff_q, ff_d;

  always_comb begin
    ff_d = ff_q;
    if (start_run) begin
      ff_d = 3'b000;
    end else if (mismatch && !ff_q[2]) begin
      ff_d = {1'b1, vec_q};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ff_q <= 3'b000;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign first_fail_o = ff_q;
`else
  assign first_fail_o = 3'b000;
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Randomized bench for gate_bist_ctrl: two instances (AND truth/settle 2, XOR truth/settle 1)
// driven by table-defined gate functions, checked every cycle against a run-level model.
module tb_gate_bist_ctrl;

  localparam int unsigned S0 = 2;
  localparam logic [3:0]  T0 = 4'b1000;
  localparam int unsigned S1 = 1;
  localparam logic [3:0]  T1 = 4'b0110;

`ifdef GATE_BIST_FAIL_LOG_EN
  localparam bit LogEn = 1'b1;
`else
  localparam bit LogEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start;
  logic go0, go1;
  logic a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
  logic [2:0] err0, ff0, err1, ff1;
  logic [1:0] vec0, vec1;
  logic [12:0] obs0, obs1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gate_bist_ctrl #(.SETTLE_CYCLES(S0), .TRUTH(T0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .gate_a_o(a0), .gate_b_o(b0),
    .gate_out_i(go0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
    .err_count_o(err0), .vec_idx_o(vec0), .first_fail_o(ff0)
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(S1), .TRUTH(T1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .gate_a_o(a1), .gate_b_o(b1),
    .gate_out_i(go1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .err_count_o(err1), .vec_idx_o(vec1), .first_fail_o(ff1)
  );

  assign obs0 = {busy0, done0, pass0, err0, vec0, a0, b0, ff0};
  assign obs1 = {busy1, done1, pass1, err1, vec1, a1, b1, ff1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Mismatches among the first n vectors the gate function fn produces against truth
  function automatic int count_mis(input logic [3:0] fn, input logic [3:0] truth, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (fn[i] != truth[i]) c++;
    return c;
  endfunction

  function automatic logic [2:0] first_mis(input logic [3:0] fn, input logic [3:0] truth,
                                           input int n);
    for (int i = 0; i < n; i++) begin
      if (fn[i] != truth[i]) return LogEn ? {1'b1, 2'(i)} : 3'b000;
    end
    return 3'b000;
  endfunction

  // Expected observable bundle in cycle cyc of a run (cyc 0 = first busy cycle)
  function automatic logic [12:0] expect_state(input logic [3:0] fn, input logic [3:0] truth,
                                               input int s, input int cyc);
    int len = 4 * (s + 1);
    int v, e;
    logic [1:0] vv;
    if (cyc < len) begin
      v  = cyc / (s + 1);
      vv = 2'(v);
      e  = count_mis(fn, truth, v);
      return {1'b1, 1'b0, 1'b0, 3'(e), vv, vv[1], vv[0], first_mis(fn, truth, v)};
    end
    e = count_mis(fn, truth, 4);
    return {1'b0, 1'b1, (e == 0), 3'(e), 2'd3, 1'b0, 1'b0, first_mis(fn, truth, 4)};
  endfunction

  // Gate output presented in cycle cyc: true value only in the sampling cycle, inverted before
  function automatic logic gate_val(input logic [3:0] fn, input int s, input int cyc);
    int len = 4 * (s + 1);
    logic val;
    if (cyc >= len) return 1'b0;
    val = fn[cyc / (s + 1)];
    return ((cyc % (s + 1)) == s) ? val : ~val;
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_d0"}, 32'(obs0), 32'd0);
    check_eq({tag, "_d1"}, 32'(obs1), 32'd0);
  endtask

  // One run on both instances; mid_at re-pulses start while busy, abort_at applies rst
  task automatic run(input logic [3:0] f0, input logic [3:0] f1, input int mid_at,
                     input int abort_at);
    int len0 = 4 * (S0 + 1);
    start = 1'b1;
    go0   = 1'b0;
    go1   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc <= len0; cyc++) begin
      if (cyc == abort_at) begin
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        go0 = 1'b0;
        go1 = 1'b0;
        check_idle("abort");
        return;
      end
      check_eq($sformatf("run0_c%0d", cyc), 32'(obs0), 32'(expect_state(f0, T0, S0, cyc)));
      check_eq($sformatf("run1_c%0d", cyc), 32'(obs1), 32'(expect_state(f1, T1, S1, cyc)));
      go0   = gate_val(f0, S0, cyc);
      go1   = gate_val(f1, S1, cyc);
      start = (cyc == mid_at);
      if (cyc < len0) @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] r0, r1;
    int mid, abt;
    rst   = 1'b1;
    start = 1'b1;
    go0   = 1'b0;
    go1   = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_with_start");
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("idle");

    run(4'b1000, 4'b0110, -1, -1);  // good AND / good XOR
    run(4'b1111, 4'b1000, -1, -1);  // stuck-at-1 / AND on XOR truth
    run(4'b0000, 4'b1111, 3, -1);   // re-pulse start during vector 1
    run(4'b1000, 4'b0110, 5, -1);
    run(4'b1000, 4'b0110, -1, 7);   // rst during vector 2
    run(4'b1000, 4'b0110, -1, -1);

    // rst and start together from DONE
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_idle("rst_and_start");
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("post_rst");

    for (int k = 0; k < 24; k++) begin
      r0  = 4'($urandom_range(0, 15));
      r1  = 4'($urandom_range(0, 15));
      mid = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 7));
      abt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 11)) : -1;
      run(r0, r1, mid, abt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
